// File: rtl/nmr_phase_sched_if.sv
// Control, configuration and status bundle for the NMR phase scheduler.
interface nmr_phase_sched_if;
  logic        work;
  logic        start;
  logic        abort;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [1:0]  last_ph;
  logic [7:0]  reps;
  logic        busy;
  logic [1:0]  phase;
  logic        ph_end;
  logic        done;
  logic        timeup;
  logic        cfg_err;

  modport master (
    output work, start, abort, cfg_we, cfg_addr, cfg_data, last_ph, reps,
    input  busy, phase, ph_end, done, timeup, cfg_err
  );

  modport slave (
    input  work, start, abort, cfg_we, cfg_addr, cfg_data, last_ph, reps,
    output busy, phase, ph_end, done, timeup, cfg_err
  );
endinterface

// File: rtl/nmr_phase_sched.sv
// NMR phase scheduler: steps through a table of phase durations counted in
// 5 kHz timebase ticks, optionally repeating the table several times.
module nmr_phase_sched #(
  parameter int NPH = 4
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              clk_5K,
  nmr_phase_sched_if.slave  sif
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, NEXT, FIN} state_t;

  localparam logic [2:0] NPH_L = 3'(NPH);

  state_t      state_q, state_d;
  logic [15:0] dur_q [NPH];
  logic [15:0] count_q, count_d;
  logic [15:0] cur_q, cur_d;
  logic [1:0]  phase_q, phase_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  pass_q, pass_d;
  logic [7:0]  reps_q, reps_d;
  logic        timeup_q, timeup_d;
  logic        err_q, err_d;
  logic        abrt_q, abrt_d;
  logic        s1_q, s2_q, s3_q;
  logic        tick;
  logic        cfg_wr_ok;
  logic        cfg_wr_bad;

  // Two-flop synchroniser for the asynchronous timebase plus edge history
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= clk_5K;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick       = s2_q & ~s3_q & ~sif.work;
  assign cfg_wr_ok  = sif.cfg_we && (state_q == IDLE) && ({1'b0, sif.cfg_addr} < NPH_L);
  assign cfg_wr_bad = sif.cfg_we && (state_q != IDLE);

  // Duration table: writable only from IDLE, persists across sequences
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      dur_q <= '{default: '0};
    end else if (cfg_wr_ok) begin
      dur_q[sif.cfg_addr] <= sif.cfg_data;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      cur_q    <= '0;
      phase_q  <= '0;
      last_q   <= '0;
      pass_q   <= '0;
      reps_q   <= '0;
      timeup_q <= 1'b0;
      err_q    <= 1'b0;
      abrt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      cur_q    <= cur_d;
      phase_q  <= phase_d;
      last_q   <= last_d;
      pass_q   <= pass_d;
      reps_q   <= reps_d;
      timeup_q <= timeup_d;
      err_q    <= err_d;
      abrt_q   <= abrt_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    cur_d    = cur_q;
    phase_d  = phase_q;
    last_d   = last_q;
    pass_d   = pass_q;
    reps_d   = reps_q;
    timeup_d = timeup_q;
    err_d    = err_q;
    abrt_d   = abrt_q;
    unique case (state_q)
      IDLE: begin
        if (sif.start) begin
          if ({1'b0, sif.last_ph} >= NPH_L) begin
            err_d = 1'b1;
          end else begin
            last_d   = sif.last_ph;
            reps_d   = sif.reps;
            timeup_d = 1'b0;
            err_d    = 1'b0;
            abrt_d   = 1'b0;
            phase_d  = '0;
            pass_d   = '0;
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        count_d = '0;
        cur_d   = dur_q[phase_q];
        if (sif.abort) begin
          abrt_d  = 1'b1;
          state_d = FIN;
        end else if (dur_q[phase_q] == '0) begin
          state_d = NEXT;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (sif.abort) begin
          abrt_d  = 1'b1;
          state_d = FIN;
        end else if (tick) begin
          count_d = count_q + 16'd1;
          if (count_q + 16'd1 == cur_q) state_d = NEXT;
        end
      end
      NEXT: begin
        if (sif.abort) begin
          abrt_d  = 1'b1;
          state_d = FIN;
        end else if (phase_q < last_q) begin
          phase_d = phase_q + 2'd1;
          state_d = LOAD;
        end else if (pass_q < reps_q) begin
          phase_d = '0;
          pass_d  = pass_q + 8'd1;
          state_d = LOAD;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        if (!abrt_q) timeup_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cfg_wr_bad) err_d = 1'b1;
  end

  // Moore status outputs
  always_comb begin
    sif.busy    = (state_q == LOAD) || (state_q == RUN) || (state_q == NEXT);
    sif.ph_end  = (state_q == NEXT);
    sif.done    = (state_q == FIN);
    sif.phase   = phase_q;
    sif.timeup  = timeup_q;
    sif.cfg_err = err_q;
  end

endmodule

// File: tb/tb_nmr_phase_sched.sv
// Directed bench for nmr_phase_sched with NPH=4 and NPH=3 instances.
module tb_nmr_phase_sched;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  logic clk_5K  = 1'b0;
  int   n_chk   = 0;
  int   n_err   = 0;
  int   ph_cnt  = 0;
  int   done_cnt = 0;
  int   p0, d0;

  int exp038_ph [8]  = '{0, 0, 1, 1, 1, 1, 1, 2};
  int exp038_dn [8]  = '{0, 0, 0, 0, 0, 0, 0, 1};
  int exp039_ph [12] = '{0, 2, 2, 2, 2, 3, 3, 5, 5, 5, 5, 6};
  int exp039_dn [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  nmr_phase_sched_if if4 ();
  nmr_phase_sched_if if3 ();

  nmr_phase_sched #(.NPH(4)) u_dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clk_5K  (clk_5K),
    .sif     (if4)
  );

  nmr_phase_sched #(.NPH(3)) u_dut3 (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clk_5K  (clk_5K),
    .sif     (if3)
  );

  assign if3.work     = if4.work;
  assign if3.start    = if4.start;
  assign if3.abort    = if4.abort;
  assign if3.cfg_we   = if4.cfg_we;
  assign if3.cfg_addr = if4.cfg_addr;
  assign if3.cfg_data = if4.cfg_data;
  assign if3.last_ph  = if4.last_ph;
  assign if3.reps     = if4.reps;

  always #5 clk_sys = ~clk_sys;

  // Count cycles where the pulses are high (a stretched pulse counts twice)
  always @(negedge clk_sys) begin
    if (if4.ph_end) ph_cnt <= ph_cnt + 1;
    if (if4.done)   done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic tick_once();
    clk_5K = 1'b1;
    cyc(4);
    clk_5K = 1'b0;
    cyc(4);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    if4.cfg_we   = 1'b1;
    if4.cfg_addr = a;
    if4.cfg_data = d;
    cyc(1);
    if4.cfg_we   = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] lp, input logic [7:0] rp, input logic ab);
    if4.last_ph = lp;
    if4.reps    = rp;
    if4.start   = 1'b1;
    if4.abort   = ab;
    cyc(1);
    if4.start   = 1'b0;
    if4.abort   = 1'b0;
  endtask

  task automatic do_abort();
    if4.abort = 1'b1;
    cyc(1);
    if4.abort = 1'b0;
  endtask

  initial begin
    if4.work = 1'b0; if4.start = 1'b0; if4.abort = 1'b0; if4.cfg_we = 1'b0;
    if4.cfg_addr = '0; if4.cfg_data = '0; if4.last_ph = '0; if4.reps = '0;

    // Reset state
    cyc(3);
    chk("rst_busy",   {31'b0, if4.busy},    0);
    chk("rst_phase",  {30'b0, if4.phase},   0);
    chk("rst_done",   {31'b0, if4.done},    0);
    chk("rst_timeup", {31'b0, if4.timeup},  0);
    chk("rst_cfgerr", {31'b0, if4.cfg_err}, 0);
    rst_n = 1'b1;
    cyc(2);

    // Two phases 3 + 5 ticks, single pass
    cfg_write(2'd0, 16'd3);
    cfg_write(2'd1, 16'd5);
    p0 = ph_cnt; d0 = done_cnt;
    do_start(2'd1, 8'd0, 1'b0);
    chk("t038_busy", {31'b0, if4.busy}, 1);
    for (int i = 0; i < 8; i++) begin
      tick_once();
      chk($sformatf("t038_ph%0d", i + 1), ph_cnt - p0,   exp038_ph[i]);
      chk($sformatf("t038_dn%0d", i + 1), done_cnt - d0, exp038_dn[i]);
      if (i == 2) chk("t038_phase", {30'b0, if4.phase}, 1);
    end
    chk("t038_timeup", {31'b0, if4.timeup}, 1);
    chk("t038_idle",   {31'b0, if4.busy},   0);
    chk("t038_hold",   {30'b0, if4.phase},  1);

    // Three phases {2,0,4}, two passes; start with abort acts as start
    cfg_write(2'd0, 16'd2);
    cfg_write(2'd1, 16'd0);
    cfg_write(2'd2, 16'd4);
    p0 = ph_cnt; d0 = done_cnt;
    do_start(2'd2, 8'd1, 1'b1);
    chk("t039_busy", {31'b0, if4.busy},   1);
    chk("t039_tclr", {31'b0, if4.timeup}, 0);
    for (int i = 0; i < 12; i++) begin
      tick_once();
      chk($sformatf("t039_ph%0d", i + 1), ph_cnt - p0,   exp039_ph[i]);
      chk($sformatf("t039_dn%0d", i + 1), done_cnt - d0, exp039_dn[i]);
    end
    chk("t039_timeup", {31'b0, if4.timeup}, 1);

    // 10-tick phase with ticks 4..6 paused
    cfg_write(2'd0, 16'd10);
    p0 = ph_cnt; d0 = done_cnt;
    do_start(2'd0, 8'd0, 1'b0);
    for (int i = 1; i <= 13; i++) begin
      if4.work = (i >= 4 && i <= 6);
      tick_once();
      if4.work = 1'b0;
      if (i == 12) chk("t040_ph12", ph_cnt - p0, 0);
      if (i == 13) begin
        chk("t040_ph13", ph_cnt - p0,   1);
        chk("t040_dn13", done_cnt - d0, 1);
      end
    end

    // Abort after 3 ticks
    p0 = ph_cnt; d0 = done_cnt;
    do_start(2'd0, 8'd0, 1'b0);
    repeat (3) tick_once();
    do_abort();
    chk("t041_done",   {31'b0, if4.done}, 1);
    chk("t041_busy",   {31'b0, if4.busy}, 0);
    cyc(1);
    chk("t041_timeup", {31'b0, if4.timeup}, 0);
    chk("t041_noph",   ph_cnt - p0,   0);
    chk("t041_dn",     done_cnt - d0, 1);

    // last_ph=3 is illegal for NPH=3 only
    do_start(2'd3, 8'd0, 1'b0);
    chk("t042_err3",  {31'b0, if3.cfg_err}, 1);
    chk("t042_busy3", {31'b0, if3.busy},    0);
    chk("t042_busy4", {31'b0, if4.busy},    1);
    chk("t042_err4",  {31'b0, if4.cfg_err}, 0);
    do_abort();
    cyc(2);

    // Table write during RUN is refused and flagged
    p0 = ph_cnt; d0 = done_cnt;
    do_start(2'd0, 8'd0, 1'b0);
    chk("t042_errclr", {31'b0, if3.cfg_err}, 0);
    repeat (2) tick_once();
    cfg_write(2'd0, 16'd2);
    chk("t042_werr", {31'b0, if4.cfg_err}, 1);
    repeat (7) tick_once();
    chk("t042_ph9", ph_cnt - p0, 0);
    tick_once();
    chk("t042_ph10", ph_cnt - p0,   1);
    chk("t042_dn10", done_cnt - d0, 1);

    // Reset in the middle of a run
    cfg_write(2'd0, 16'd1);
    cfg_write(2'd1, 16'd10);
    do_start(2'd1, 8'd0, 1'b0);
    tick_once();
    chk("t043_phase1", {30'b0, if4.phase}, 1);
    tick_once();
    cfg_write(2'd2, 16'd7);
    chk("t043_err", {31'b0, if4.cfg_err}, 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    cyc(1);
    chk("t043_busy",   {31'b0, if4.busy},    0);
    chk("t043_phase",  {30'b0, if4.phase},   0);
    chk("t043_phend",  {31'b0, if4.ph_end},  0);
    chk("t043_done",   {31'b0, if4.done},    0);
    chk("t043_timeup", {31'b0, if4.timeup},  0);
    chk("t043_cfgerr", {31'b0, if4.cfg_err}, 0);
    rst_n = 1'b1;
    cyc(1);
    chk("t043_nodone", done_cnt - d0, 0);

    // Table cleared by reset: zero-length phase completes without ticks
    p0 = ph_cnt; d0 = done_cnt;
    do_start(2'd0, 8'd0, 1'b0);
    cyc(6);
    chk("t043_zph",  ph_cnt - p0,   1);
    chk("t043_zdn",  done_cnt - d0, 1);
    chk("t043_ztup", {31'b0, if4.timeup}, 1);

    // Normal run after reset
    cfg_write(2'd0, 16'd2);
    p0 = ph_cnt; d0 = done_cnt;
    do_start(2'd0, 8'd0, 1'b0);
    tick_once();
    chk("t043_rph1", ph_cnt - p0, 0);
    tick_once();
    chk("t043_rph2", ph_cnt - p0,   1);
    chk("t043_rdn2", done_cnt - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/nmr_phase_sched.md
NMR_PHASE_SCHED -- requirements
Module: nmr_phase_sched

Interface
REQ-001 SHALL have parameter NPH, default 4, number of phase-duration registers (2..4).
REQ-002 SHALL have port clk_sys  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port clk_5K  input  1  asynchronous 5 kHz timebase.
REQ-005 SHALL have port work  input  1  pause; while high, timebase ticks are ignored.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a sequence.
REQ-007 SHALL have port abort  input  1  single-cycle request to stop the sequence.
REQ-008 SHALL have port cfg_we  input  1  write strobe for the duration table.
REQ-009 SHALL have port cfg_addr  input  2  duration register index.
REQ-010 SHALL have port cfg_data  input  16  duration in ticks.
REQ-011 SHALL have port last_ph  input  2  index of the final phase; must be below NPH.
REQ-012 SHALL have port reps  input  8  extra passes over the table; 0 means a single pass.
REQ-013 SHALL have port busy  output  1  sequence in progress.
REQ-014 SHALL have port phase  output  2  current phase index.
REQ-015 SHALL have port ph_end  output  1  one-cycle pulse at the end of each phase.
REQ-016 SHALL have port done  output  1  one-cycle pulse when the sequence completes or is aborted.
REQ-017 SHALL have port timeup  output  1  level; set on completion, cleared by the next start.
REQ-018 SHALL have port cfg_err  output  1  sticky flag for an illegal configuration.

Function
REQ-019 SHALL synchronise clk_5K through two flops; tick = rise of the synchronised signal AND NOT work.
REQ-020 SHALL write dur[cfg_addr] <= cfg_data on cfg_we while in IDLE; writes outside IDLE SHALL be ignored and SHALL set cfg_err.
REQ-021 SHALL implement the states IDLE, LOAD, RUN, NEXT and FIN.
REQ-022 IDLE->LOAD on start; start SHALL latch last_ph and reps, clear timeup and cfg_err, and set phase=0 and pass=0.
REQ-023 In start, if last_ph >= NPH, cfg_err SHALL set and the block SHALL stay in IDLE with no done pulse.
REQ-024 LOAD SHALL clear the 16-bit counter, set cur = dur[phase], then go to RUN, or to NEXT in the same cycle if cur == 0 (zero-length phase, skipped).
REQ-025 RUN SHALL increment the counter on each tick; on the tick where count+1 == cur it SHALL go to NEXT.
REQ-026 Latency SHALL be exactly cur ticks from LOAD to NEXT; the counter SHALL never wrap (max 65535).
REQ-027 NEXT SHALL pulse ph_end for one cycle.
REQ-028 NEXT SHALL go to LOAD with phase+1 if phase < last_ph.
REQ-029 Otherwise NEXT SHALL go to LOAD with phase=0 and pass+1 if pass < reps.
REQ-030 Otherwise NEXT SHALL go to FIN.
REQ-031 FIN SHALL pulse done, set timeup, then return to IDLE; busy SHALL be high in LOAD, RUN and NEXT only.
REQ-032 abort in any non-IDLE state SHALL go to FIN next cycle with no ph_end and timeup NOT set; abort has priority over a tick in the same cycle.
REQ-033 start while busy SHALL be ignored; start and abort together in IDLE SHALL act as start only.
REQ-034 work high SHALL freeze count and state in RUN; a tick coinciding with work SHALL be lost.
REQ-035 phase SHALL hold its last value in IDLE; the duration table SHALL persist across sequences.

Reset
REQ-036 When rst_n=0, SHALL reset state=IDLE, count=0, phase=0, pass=0, busy=0, ph_end=0, done=0, timeup=0, cfg_err=0, sync flops=0, dur[*]=0.
REQ-037 Reset mid-sequence SHALL abandon the sequence without a done pulse.

Verification
REQ-038 dur={3,5}, last_ph=1, reps=0, start -> ph_end after 3 ticks and again 5 ticks later, done and timeup after 8 ticks total.
REQ-039 dur={2,0,4}, last_ph=2, reps=1 -> ph_end pulses at ticks 2,2,6,8,8,12; phase 1 is skipped at zero ticks; done follows the 12th tick.
REQ-040 dur0=10, work held high for ticks 4-6 -> phase end moves out by 3 ticks; count frozen during the pause.
REQ-041 abort at tick 3 of dur0=10 -> done the next cycle, timeup=0, busy=0, no ph_end.
REQ-042 last_ph=3 with NPH=3 -> cfg_err=1, busy stays 0; cfg_we during RUN -> table unchanged and cfg_err=1.
REQ-043 rst_n low during RUN -> all outputs 0 next cycle; a later start runs normally.
